// File: rtl/roic_frame_timing_gen_if.sv
// Control/status bundle between a frame sequencer and the ROIC frame timing generator.
// The slave side is the timing generator; the master side drives frame requests and config.
interface roic_frame_timing_gen_if #(
    parameter int CNT_W = 16
);
    logic             enable;
    logic             start;
    logic [CNT_W-1:0] cfg_intg_time;
    logic [CNT_W-1:0] cfg_frame_period;
    logic             fsync;
    logic             intg;
    logic             readout_active;
    logic             busy;
    logic [15:0]      frame_cnt;
    logic             period_clamped;

    modport master (
        output enable, start, cfg_intg_time, cfg_frame_period,
        input  fsync, intg, readout_active, busy, frame_cnt, period_clamped
    );

    modport slave (
        input  enable, start, cfg_intg_time, cfg_frame_period,
        output fsync, intg, readout_active, busy, frame_cnt, period_clamped
    );
endinterface

// File: rtl/roic_frame_timing_gen.sv
// Per-frame fsync / integration window generator for the matrix shift scanner,
// reserving a full readout interval after every integration window.
module roic_frame_timing_gen #(
    parameter int CNT_W       = 16,
    parameter int FSYNC_W     = 2,
    parameter int INTG_DLY    = 2,
    parameter int READOUT_CYC = 310
) (
    input  logic                        clk,
    input  logic                        master_rst,
    roic_frame_timing_gen_if.slave      bus
);
    // Two spare bits keep M = FSYNC_W + INTG_DLY + T + READOUT_CYC from overflowing.
    localparam int PW = CNT_W + 2;
    typedef logic [PW-1:0] phase_t;

    localparam phase_t FIXED_CYC = phase_t'(FSYNC_W + INTG_DLY + READOUT_CYC);

    typedef enum logic [2:0] {
        IDLE,
        FSYNC,
        PRE_INTG,
        INTEGRATE,
        READOUT,
        PAD
    } state_t;

    state_t      state, state_nxt;
    phase_t      cnt, cnt_nxt;
    phase_t      t_lat, pad_lat;
    phase_t      t_eff, min_len, req_len, pad_len;
    logic        clamp;
    logic        load_cfg, frame_done;

    logic        fsync_q, intg_q, readout_q, busy_q, clamped_q;
    logic [15:0] frame_cnt_q;

    // Frame geometry derived from the live config; only captured on load_cfg.
    always_comb begin
        t_eff   = (bus.cfg_intg_time == '0) ? phase_t'(1) : phase_t'(bus.cfg_intg_time);
        min_len = FIXED_CYC + t_eff;
        req_len = phase_t'(bus.cfg_frame_period);
        clamp   = (req_len < min_len);
        pad_len = clamp ? '0 : (req_len - min_len);
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt - phase_t'(1);
        load_cfg   = 1'b0;
        frame_done = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (bus.enable || bus.start) begin
                    state_nxt = FSYNC;
                    cnt_nxt   = phase_t'(FSYNC_W - 1);
                    load_cfg  = 1'b1;
                end
            end
            FSYNC: if (cnt == '0) begin
                state_nxt = PRE_INTG;
                cnt_nxt   = phase_t'(INTG_DLY - 1);
            end
            PRE_INTG: if (cnt == '0) begin
                state_nxt = INTEGRATE;
                cnt_nxt   = t_lat - phase_t'(1);
            end
            INTEGRATE: if (cnt == '0) begin
                state_nxt = READOUT;
                cnt_nxt   = phase_t'(READOUT_CYC - 1);
            end
            READOUT: if (cnt == '0) begin
                if (pad_lat != '0) begin
                    state_nxt = PAD;
                    cnt_nxt   = pad_lat - phase_t'(1);
                end else begin
                    frame_done = 1'b1;
                end
            end
            PAD: if (cnt == '0) frame_done = 1'b1;
            default: state_nxt = IDLE;
        endcase

        // Back-to-back frames restart at k=0 with freshly latched config.
        if (frame_done) begin
            if (bus.enable) begin
                state_nxt = FSYNC;
                cnt_nxt   = phase_t'(FSYNC_W - 1);
                load_cfg  = 1'b1;
            end else begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (master_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            t_lat       <= '0;
            pad_lat     <= '0;
            fsync_q     <= 1'b0;
            intg_q      <= 1'b0;
            readout_q   <= 1'b0;
            busy_q      <= 1'b0;
            clamped_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            if (load_cfg) begin
                t_lat     <= t_eff;
                pad_lat   <= pad_len;
                clamped_q <= clamp;
            end
            if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
            // Strobes decode the next state so they line up with it, registered.
            fsync_q   <= (state_nxt == FSYNC);
            intg_q    <= (state_nxt == INTEGRATE);
            readout_q <= (state_nxt == READOUT);
            busy_q    <= (state_nxt != IDLE);
        end
    end

    assign bus.fsync          = fsync_q;
    assign bus.intg           = intg_q;
    assign bus.readout_active = readout_q;
    assign bus.busy           = busy_q;
    assign bus.frame_cnt      = frame_cnt_q;
    assign bus.period_clamped = clamped_q;
endmodule

// File: tb/tb_roic_frame_timing_gen.sv
// Directed bench for roic_frame_timing_gen: single-shot, clamp, zero integration,
// continuous mode, busy-start rejection, mid-frame reset and frame counter wrap.
module tb_roic_frame_timing_gen;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic master_rst;
    always #5 clk = ~clk;

    roic_frame_timing_gen_if #(.CNT_W(CNT_W)) bus ();

    roic_frame_timing_gen #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .master_rst (master_rst),
        .bus        (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Per-capture observations, indexed by cycle i (i = k+1 of the first frame).
    int fs_first, fs_last, fs_cnt;
    int ig_first, ig_last, ig_cnt;
    int ro_first, ro_last, ro_cnt;
    int bz_last, excl_err, n_rise;
    int rise_at[8];
    int fc_at_rise[8];
    int ig_len[8];

    task automatic capture(input int n, input int start_at, input int drop_at,
                           input int chg_at, input int chg_val);
        logic prev_fs;
        fs_first = -1; fs_last = -1; fs_cnt = 0;
        ig_first = -1; ig_last = -1; ig_cnt = 0;
        ro_first = -1; ro_last = -1; ro_cnt = 0;
        bz_last  = -1; excl_err = 0; n_rise = 0;
        for (int j = 0; j < 8; j++) begin
            rise_at[j] = 0; fc_at_rise[j] = 0; ig_len[j] = 0;
        end
        prev_fs = 1'b0;
        for (int i = 1; i <= n; i++) begin
            if (bus.fsync && !prev_fs) begin
                if (n_rise < 8) begin
                    rise_at[n_rise]    = i;
                    fc_at_rise[n_rise] = int'(bus.frame_cnt);
                end
                n_rise++;
            end
            prev_fs = bus.fsync;
            if (bus.fsync) begin
                if (fs_first < 0) fs_first = i;
                fs_last = i; fs_cnt++;
            end
            if (bus.intg) begin
                if (ig_first < 0) ig_first = i;
                ig_last = i; ig_cnt++;
                if (n_rise > 0 && n_rise <= 8) ig_len[n_rise-1]++;
            end
            if (bus.readout_active) begin
                if (ro_first < 0) ro_first = i;
                ro_last = i; ro_cnt++;
            end
            if (bus.busy) bz_last = i;
            if (int'(bus.fsync) + int'(bus.intg) + int'(bus.readout_active) > 1) excl_err++;
            bus.start = (i == start_at);
            if (i == drop_at) bus.enable = 1'b0;
            if (i == chg_at) bus.cfg_intg_time = CNT_W'(chg_val);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
    endtask

    task automatic do_reset();
        master_rst           = 1'b1;
        bus.enable           = 1'b0;
        bus.start            = 1'b0;
        bus.cfg_intg_time    = '0;
        bus.cfg_frame_period = '0;
        repeat (2) @(posedge clk);
        #1;
        master_rst = 1'b0;
    endtask

    // Presents a request that is sampled at the next edge (edge t); returns in cycle t+1.
    task automatic launch(input bit use_enable, input int t, input int p);
        bus.cfg_intg_time    = CNT_W'(t);
        bus.cfg_frame_period = CNT_W'(p);
        if (use_enable) bus.enable = 1'b1;
        else            bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    initial begin
        do_reset();
        master_rst = 1'b1;
        @(posedge clk); #1;
        check("rst_strobes", {bus.fsync, bus.intg, bus.readout_active, bus.busy, bus.period_clamped}, 0);
        check("rst_frame_cnt", bus.frame_cnt, 0);
        master_rst = 1'b0;

        // Single shot T=100 P=1000, extra start pulse during INTEGRATE must be ignored.
        launch(1'b0, 100, 1000);
        capture(1100, 50, 0, 0, 0);
        check("ss_fsync_first", fs_first, 1);
        check("ss_fsync_last", fs_last, 2);
        check("ss_fsync_cycles", fs_cnt, 2);
        check("ss_intg_first", ig_first, 5);
        check("ss_intg_last", ig_last, 104);
        check("ss_intg_cycles", ig_cnt, 100);
        check("ss_ro_first", ro_first, 105);
        check("ss_ro_last", ro_last, 414);
        check("ss_ro_cycles", ro_cnt, 310);
        check("ss_busy_last", bz_last, 1000);
        check("ss_frame_cnt", bus.frame_cnt, 1);
        check("ss_clamped", bus.period_clamped, 0);
        check("ss_exclusive", excl_err, 0);

        // Zero integration, zero period: one intg cycle at k=4, L=315.
        do_reset();
        launch(1'b0, 0, 0);
        capture(400, 0, 0, 0, 0);
        check("z_intg_first", ig_first, 5);
        check("z_intg_cycles", ig_cnt, 1);
        check("z_ro_first", ro_first, 6);
        check("z_busy_last", bz_last, 315);
        check("z_clamped", bus.period_clamped, 1);
        check("z_frame_cnt", bus.frame_cnt, 1);

        // Mid-frame reset at k=60, then a clean restart.
        launch(1'b0, 100, 1000);
        capture(60, 0, 0, 0, 0);
        check("mr_intg_k60", bus.intg, 1);
        check("mr_cnt_before", bus.frame_cnt, 1);
        master_rst = 1'b1;
        @(posedge clk); #1;
        check("mr_strobes", {bus.fsync, bus.intg, bus.readout_active, bus.busy, bus.period_clamped}, 0);
        check("mr_frame_cnt", bus.frame_cnt, 0);
        master_rst = 1'b0;
        launch(1'b0, 100, 1000);
        capture(420, 0, 0, 0, 0);
        check("mr_fsync_first", fs_first, 1);
        check("mr_intg_first", ig_first, 5);
        check("mr_still_busy", bz_last, 420);
        check("mr_no_complete", bus.frame_cnt, 0);

        // Clamp in continuous mode: T=100 P=200 -> L=414; enable drops at k=5 of frame 2.
        do_reset();
        launch(1'b1, 100, 200);
        capture(900, 0, 420, 0, 0);
        check("cl_rises", n_rise, 2);
        check("cl_spacing", rise_at[1] - rise_at[0], 414);
        check("cl_busy_last", bz_last, 828);
        check("cl_clamped", bus.period_clamped, 1);
        check("cl_frame_cnt", bus.frame_cnt, 2);

        // Continuous T=50 P=500; T->80 during frame 1, enable drops at k=20 of frame 3.
        do_reset();
        launch(1'b1, 50, 500);
        capture(1600, 0, 1021, 30, 80);
        check("ct_rises", n_rise, 3);
        check("ct_rise2", rise_at[1], 501);
        check("ct_rise3", rise_at[2], 1001);
        check("ct_cnt_at_rise2", fc_at_rise[1], 1);
        check("ct_cnt_at_rise3", fc_at_rise[2], 2);
        check("ct_intg_frame1", ig_len[0], 50);
        check("ct_intg_frame2", ig_len[1], 80);
        check("ct_busy_last", bz_last, 1500);
        check("ct_frame_cnt", bus.frame_cnt, 3);
        check("ct_clamped", bus.period_clamped, 0);
        check("ct_exclusive", excl_err, 0);

        // Counter wrap: preload 65535 completed frames, one more frame wraps to 0.
        do_reset();
        force dut.frame_cnt_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.frame_cnt_q;
        @(posedge clk); #1;
        check("wr_preload", bus.frame_cnt, 16'hFFFF);
        launch(1'b0, 0, 0);
        capture(320, 0, 0, 0, 0);
        check("wr_busy_last", bz_last, 315);
        check("wr_frame_cnt", bus.frame_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
